// File: rtl/gen_meas_pkg.sv
// gen_meas_pkg: shared definitions for the gen_meas tone-measurement block.
//   - FSM state encoding
//   - readback select codes
//   - sample width and signed sample limits
package gen_meas_pkg;

    localparam int SAMP_W = 18;

    localparam logic signed [SAMP_W-1:0] SAMP_MAX = 18'sh1FFFF;  //  131071
    localparam logic signed [SAMP_W-1:0] SAMP_MIN = 18'sh20000;  // -131072

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_MAX  = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_ZC   = 2'd2;
    localparam logic [1:0] SEL_STAT = 2'd3;

endpackage

// File: rtl/gen_meas_if.sv
// gen_meas_if: sample stream, CPU config strobes and readback of gen_meas.
//   master : test generator / CPU side (drives samples, strobes, rd_sel)
//   slave  : gen_meas side (drives busy, done, rd_data)
interface gen_meas_if;
    import gen_meas_pkg::*;

    logic signed [SAMP_W-1:0] in_data;
    logic                     in_valid;
    logic [31:0]              cfg_data;
    logic                     set_window;
    logic                     set_hyst;
    logic                     start;
    logic [1:0]               rd_sel;
    logic                     busy;
    logic                     done;
    logic [31:0]              rd_data;

    modport master (
        output in_data, in_valid, cfg_data, set_window, set_hyst, start, rd_sel,
        input  busy, done, rd_data
    );

    modport slave (
        input  in_data, in_valid, cfg_data, set_window, set_hyst, start, rd_sel,
        output busy, done, rd_data
    );

endinterface

// File: rtl/gen_meas_zc_detect.sv
// zc_detect: positive-going zero-crossing detector for gen_meas.
// Build option GEN_MEAS_HYST_EN selects the hysteresis detector (arm below
// -hyst, count at or above +hyst); otherwise a plain sign-change detector.
// Ports:
//   adc_clk, adc_rst_n : clock, async active-low reset
//   i_sample, i_valid  : sample stream (only valid samples advance state)
//   i_clear            : forget history; wins over i_valid
//   i_hyst             : unsigned hysteresis (GEN_MEAS_HYST_EN builds only)
//   o_cross            : combinational, high on the valid sample that crosses
module zc_detect
    import gen_meas_pkg::*;
(
    input  logic                     adc_clk,
    input  logic                     adc_rst_n,
    input  logic signed [SAMP_W-1:0] i_sample,
    input  logic                     i_valid,
    input  logic                     i_clear,
`ifdef GEN_MEAS_HYST_EN
    input  logic [16:0]              i_hyst,
`endif
    output logic                     o_cross
);

`ifdef GEN_MEAS_HYST_EN
    // One extra bit so -hyst and +hyst both fit alongside any sample.
    logic signed [SAMP_W:0] w_samp;
    logic signed [SAMP_W:0] w_hyst_p;
    logic signed [SAMP_W:0] w_hyst_n;
    logic                   r_armed;

    assign w_samp   = {i_sample[SAMP_W-1], i_sample};
    assign w_hyst_p = $signed({2'b00, i_hyst});
    assign w_hyst_n = -w_hyst_p;
    assign o_cross  = i_valid && !i_clear && r_armed && (w_samp >= w_hyst_p);

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_armed <= 1'b0;
        end else if (i_clear) begin
            r_armed <= 1'b0;
        end else if (i_valid) begin
            if (o_cross)
                r_armed <= 1'b0;
            else if (w_samp < w_hyst_n)
                r_armed <= 1'b1;
        end
    end
`else
    logic r_have_prev;
    logic r_prev_neg;

    assign o_cross = i_valid && !i_clear && r_have_prev && r_prev_neg && !i_sample[SAMP_W-1];

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_have_prev <= 1'b0;
            r_prev_neg  <= 1'b0;
        end else if (i_clear) begin
            r_have_prev <= 1'b0;
            r_prev_neg  <= 1'b0;
        end else if (i_valid) begin
            r_have_prev <= 1'b1;
            r_prev_neg  <= i_sample[SAMP_W-1];
        end
    end
`endif

endmodule

// File: rtl/gen_meas.sv
// gen_meas: measures peak max/min and positive zero crossings of the test
// generator sample stream over a CPU-programmed window of valid samples.
// Build option GEN_MEAS_HYST_EN enables the hyst register and hysteresis
// zero-crossing detection.
// Ports:
//   adc_clk, adc_rst_n : sample clock, async active-low reset
//   bus (slave)        : samples, cfg strobes, start, rd_sel / busy, done, rd_data
//
// state   | meaning
// IDLE    | waiting for start with a nonzero window length
// RUN     | accumulating peaks, crossings and sample count
// DONE    | publish live results to shadows, pulse done
module gen_meas
    import gen_meas_pkg::*;
#(
    parameter int WIN_W = 24,
    parameter int ZC_W  = 16
) (
    input  logic       adc_clk,
    input  logic       adc_rst_n,
    gen_meas_if.slave  bus
);

    state_t                   r_state;
    logic [WIN_W-1:0]         r_window_len;
    logic [WIN_W-1:0]         r_win_cap;
    logic [WIN_W-1:0]         r_cnt;
    logic signed [SAMP_W-1:0] r_max;
    logic signed [SAMP_W-1:0] r_min;
    logic [ZC_W-1:0]          r_zc;
    logic signed [SAMP_W-1:0] r_max_sh;
    logic signed [SAMP_W-1:0] r_min_sh;
    logic [ZC_W-1:0]          r_zc_sh;
    logic                     r_busy;
    logic                     r_done;
    logic [31:0]              r_rd_data;

    logic w_go;
    logic w_samp_valid;
    logic w_last;
    logic w_cross;
    logic w_unused;

    // A start with a zero window is ignored in every state.
    assign w_go         = bus.start && (r_window_len != '0);
    assign w_samp_valid = (r_state == ST_RUN) && bus.in_valid && !w_go;
    assign w_last       = (r_cnt == r_win_cap - 1'b1);

`ifdef GEN_MEAS_HYST_EN
    logic [16:0] r_hyst;

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n)
            r_hyst <= '0;
        else if (bus.set_hyst)
            r_hyst <= bus.cfg_data[16:0];
    end

    assign w_unused = &{1'b0, bus.cfg_data};
`else
    assign w_unused = &{1'b0, bus.cfg_data, bus.set_hyst};
`endif

    zc_detect u_zc (
        .adc_clk   (adc_clk),
        .adc_rst_n (adc_rst_n),
        .i_sample  (bus.in_data),
        .i_valid   (w_samp_valid),
        .i_clear   (w_go),
`ifdef GEN_MEAS_HYST_EN
        .i_hyst    (r_hyst),
`endif
        .o_cross   (w_cross)
    );

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_state      <= ST_IDLE;
            r_window_len <= '0;
            r_win_cap    <= '0;
            r_cnt        <= '0;
            r_max        <= SAMP_MIN;
            r_min        <= SAMP_MAX;
            r_zc         <= '0;
            r_max_sh     <= '0;
            r_min_sh     <= '0;
            r_zc_sh      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (bus.set_window)
                r_window_len <= bus.cfg_data[WIN_W-1:0];

            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A restart on the final sample discards the window.
                    if (!w_go && bus.in_valid && w_last)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_max_sh <= r_max;
                    r_min_sh <= r_min;
                    r_zc_sh  <= r_zc;
                    r_done   <= 1'b1;
                    if (w_go) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_go) begin
                r_win_cap <= r_window_len;
                r_cnt     <= '0;
                r_max     <= SAMP_MIN;
                r_min     <= SAMP_MAX;
                r_zc      <= '0;
            end else if (w_samp_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (bus.in_data > r_max)
                    r_max <= bus.in_data;
                if (bus.in_data < r_min)
                    r_min <= bus.in_data;
                if (w_cross && (r_zc != {ZC_W{1'b1}}))
                    r_zc <= r_zc + 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_rd_data <= '0;
        end else begin
            case (bus.rd_sel)
                SEL_MAX:  r_rd_data <= {{(32-SAMP_W){r_max_sh[SAMP_W-1]}}, r_max_sh};
                SEL_MIN:  r_rd_data <= {{(32-SAMP_W){r_min_sh[SAMP_W-1]}}, r_min_sh};
                SEL_ZC:   r_rd_data <= 32'(r_zc_sh);
                default:  r_rd_data <= {r_busy, 7'b0, 24'(r_window_len)};
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_data = r_rd_data;

endmodule
